// File: rtl/deserializador32_pkg.sv
// deserializador32_pkg: encodings shared by the shift register, the
// deserializer, the probador and the verificador.
//   MODO_*  : control bus mode encodings
//   ST_*    : deserializer FSM state encodings
//   DIR_*   : shift direction (1 = left / MSB first, 0 = right / LSB first)
//   ctrl_t / decodeCtrl : decoded view of ENB+MODO as seen by the consumer
package deserializador32_pkg;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef struct packed {
    logic capture;  // one serial bit leaves the register this cycle
    logic load;     // register is being parallel-loaded
  } ctrl_t;

  // Rotate and hold never consume the serial output, so they decode to idle.
  function automatic ctrl_t decodeCtrl(input logic enb, input logic [1:0] modo);
    ctrl_t c;
    c.capture = enb && (modo == MODO_SHIFT);
    c.load    = enb && (modo == MODO_LOAD);
    return c;
  endfunction

endpackage

// File: rtl/deserializador32_if.sv
// deserializador32_if: control/serial inputs and word/status outputs of the
// deserializer.
//   ENB, MODO, DIR, S_IN : same control bus that drives the shift register
//   Q, VALID             : completed word and its one-cycle strobe
//   CNT                  : bits captured in the current frame
//   ALERTA               : one-cycle frame-error pulse
//   PAR                  : parity of Q (only with DESER_PARITY_EN)
// master = stimulus side, slave = deserializer.
interface deserializador32_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
);
  logic             ENB;
  logic [1:0]       MODO;
  logic             DIR;
  logic             S_IN;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic [CW-1:0]    CNT;
  logic             ALERTA;
`ifdef DESER_PARITY_EN
  logic             PAR;

  modport master (output ENB, MODO, DIR, S_IN, input Q, VALID, CNT, ALERTA, PAR);
  modport slave  (input ENB, MODO, DIR, S_IN, output Q, VALID, CNT, ALERTA, PAR);
`else
  modport master (output ENB, MODO, DIR, S_IN, input Q, VALID, CNT, ALERTA);
  modport slave  (input ENB, MODO, DIR, S_IN, output Q, VALID, CNT, ALERTA);
`endif
endinterface

// File: rtl/deserializador32_contador_frame.sv
// contador_frame: CW-bit frame bit counter.
//   CLK, RST_L : clock, asynchronous active-low reset
//   clr, inc   : clear and increment; both together restart the count at 1
//   cnt        : current count
//   term       : cnt == WIDTH-1 (next capture completes the word)
module contador_frame #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic          CLK,
  input  logic          RST_L,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          term
);

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L)
      cnt <= '0;
    else if (clr || inc)
      cnt <= (clr ? '0 : cnt) + CW'(inc);
  end

  assign term = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/deserializador32.sv
// deserializador32: rebuilds parallel words from the shift register's serial
// output, following the same ENB/MODO/DIR bus that drives the register.
//   CLK, RST_L : clock shared with the register, asynchronous active-low reset
//   bus        : deserializador32_if slave (ENB, MODO, DIR, S_IN in;
//                Q, VALID, CNT, ALERTA [, PAR] out)
// Optional feature: define DESER_PARITY_EN to add PAR = ^Q, updated with VALID.
// WIDTH must be >= 2 and 2**CW > WIDTH.
module deserializador32
  import deserializador32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input logic                CLK,
  input logic                RST_L,
  deserializador32_if.slave  bus
);

  logic [0:0]       state, stateNext;
  logic             dirF;
  logic [WIDTH-1:0] acc, accNext, q;
  logic             valid, alerta;
  logic             cntClr, cntInc, term;
  logic             doWord, doAlert, doDiscard, setDir;
  logic [CW-1:0]    cnt;
  ctrl_t            ctrl;

  assign ctrl    = decodeCtrl(bus.ENB, bus.MODO);
  assign accNext = (bus.DIR == DIR_LEFT) ? {acc[WIDTH-2:0], bus.S_IN}
                                         : {bus.S_IN, acc[WIDTH-1:1]};

  always_comb begin
    stateNext = state;
    cntClr    = 1'b0;
    cntInc    = 1'b0;
    doWord    = 1'b0;
    doAlert   = 1'b0;
    doDiscard = 1'b0;
    setDir    = 1'b0;
    if (state == ST_IDLE) begin
      if (ctrl.capture) begin
        cntInc    = 1'b1;
        setDir    = 1'b1;
        stateNext = ST_RECV;
      end
    end else begin
      if (ctrl.capture) begin
        // A direction flip wins over completion: the old frame is corrupt
        // and this bit opens a new one.
        if (bus.DIR != dirF) begin
          doAlert = 1'b1;
          cntClr  = 1'b1;
          cntInc  = 1'b1;
          setDir  = 1'b1;
        end else if (term) begin
          doWord    = 1'b1;
          cntClr    = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          cntInc = 1'b1;
        end
      end else if (ctrl.load) begin
        doAlert   = 1'b1;
        doDiscard = 1'b1;
        cntClr    = 1'b1;
        stateNext = ST_IDLE;
      end
    end
  end

  contador_frame #(.WIDTH(WIDTH), .CW(CW)) uCnt (
    .CLK   (CLK),
    .RST_L (RST_L),
    .clr   (cntClr),
    .inc   (cntInc),
    .cnt   (cnt),
    .term  (term)
  );

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state  <= ST_IDLE;
      dirF   <= DIR_RIGHT;
      acc    <= '0;
      q      <= '0;
      valid  <= 1'b0;
      alerta <= 1'b0;
    end else begin
      state  <= stateNext;
      valid  <= doWord;
      alerta <= doAlert;
      if (setDir)
        dirF <= bus.DIR;
      // Stale bits left in acc by a restarted frame are shifted out before
      // the word completes, so acc never needs clearing on capture.
      if (doDiscard)
        acc <= '0;
      else if (ctrl.capture)
        acc <= accNext;
      if (doWord)
        q <= accNext;
    end
  end

`ifdef DESER_PARITY_EN
  logic par;
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L)
      par <= 1'b0;
    else if (doWord)
      par <= ^accNext;
  end
  assign bus.PAR = par;
`endif

  assign bus.Q      = q;
  assign bus.VALID  = valid;
  assign bus.CNT    = cnt;
  assign bus.ALERTA = alerta;

endmodule

// File: tb/tb_deserializador32.sv
// tb_deserializador32: directed self-checking bench for deserializador32.
module tb_deserializador32;
  import deserializador32_pkg::*;

  logic CLK = 1'b0;
  logic RST_L;
  int   nChk = 0;
  int   nFail = 0;
  int   vCnt = 0;
  int   aCnt = 0;

  deserializador32_if #(.WIDTH(32), .CW(6)) bus ();

  deserializador32 #(.WIDTH(32), .CW(6)) dut (
    .CLK   (CLK),
    .RST_L (RST_L),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.VALID)  vCnt++;
    if (bus.ALERTA) aCnt++;
  endtask

  task automatic drive(input logic enb, input logic [1:0] modo, input logic dir, input logic sin);
    bus.ENB  = enb;
    bus.MODO = modo;
    bus.DIR  = dir;
    bus.S_IN = sin;
    tick();
  endtask

  // Shift in n bits of w starting at bit position 'from' in transmit order.
  task automatic sendBits(input logic [31:0] w, input logic dir, input int from, input int n);
    for (int i = from; i < from + n; i++)
      drive(1'b1, MODO_SHIFT, dir, dir ? w[31-i] : w[i]);
  endtask

  initial begin
    logic [31:0] w;

    RST_L    = 1'b0;
    bus.ENB  = 1'b0;
    bus.MODO = MODO_HOLD;
    bus.DIR  = 1'b0;
    bus.S_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", bus.Q, 32'h0);
    chk("rst_cnt", 32'(bus.CNT), 32'd0);
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    chk("rst_alerta", 32'(bus.ALERTA), 32'd0);
    RST_L = 1'b1;

    // MSB-first frame
    w = 32'hA5C3_0F81;
    vCnt = 0; aCnt = 0;
    sendBits(w, DIR_LEFT, 0, 31);
    chk("msb_cnt31", 32'(bus.CNT), 32'd31);
    chk("msb_no_early_valid", 32'(vCnt), 32'd0);
    sendBits(w, DIR_LEFT, 31, 1);
    chk("msb_valid", 32'(bus.VALID), 32'd1);
    chk("msb_q", bus.Q, 32'hA5C3_0F81);
    chk("msb_cnt0", 32'(bus.CNT), 32'd0);
    chk("msb_no_alert", 32'(aCnt), 32'd0);
`ifdef DESER_PARITY_EN
    chk("msb_par", 32'(bus.PAR), 32'd0);
`endif
    drive(1'b0, MODO_SHIFT, DIR_LEFT, 1'b1);
    chk("msb_valid_pulse", 32'(bus.VALID), 32'd0);
    chk("msb_q_hold", bus.Q, 32'hA5C3_0F81);

    // LSB-first frame
    w = 32'h0000_0001;
    vCnt = 0;
    sendBits(w, DIR_RIGHT, 0, 31);
    chk("lsb_no_early_valid", 32'(vCnt), 32'd0);
    sendBits(w, DIR_RIGHT, 31, 1);
    chk("lsb_valid", 32'(bus.VALID), 32'd1);
    chk("lsb_q", bus.Q, 32'h0000_0001);
`ifdef DESER_PARITY_EN
    chk("lsb_par", 32'(bus.PAR), 32'd1);
`endif

    // Truncated frame followed by LOAD
    w = 32'hFFC0_0000;
    vCnt = 0; aCnt = 0;
    sendBits(w, DIR_LEFT, 0, 10);
    chk("trunc_cnt10", 32'(bus.CNT), 32'd10);
    drive(1'b1, MODO_LOAD, DIR_LEFT, 1'b0);
    chk("trunc_alerta", 32'(bus.ALERTA), 32'd1);
    chk("trunc_cnt0", 32'(bus.CNT), 32'd0);
    chk("trunc_q_kept", bus.Q, 32'h0000_0001);
    chk("trunc_no_valid", 32'(bus.VALID), 32'd0);
    drive(1'b1, MODO_LOAD, DIR_LEFT, 1'b0);
    chk("idle_load_no_alert", 32'(bus.ALERTA), 32'd0);
    chk("idle_load_cnt", 32'(bus.CNT), 32'd0);
    chk("trunc_alert_count", 32'(aCnt), 32'd1);

    // Direction flip on the 6th capture restarts the frame LSB-first
    w = 32'hFFFF_0000;
    sendBits(w, DIR_LEFT, 0, 5);
    chk("flip_cnt5", 32'(bus.CNT), 32'd5);
    w = 32'hDEAD_BEEF;
    vCnt = 0; aCnt = 0;
    sendBits(w, DIR_RIGHT, 0, 1);
    chk("flip_alerta", 32'(bus.ALERTA), 32'd1);
    chk("flip_cnt1", 32'(bus.CNT), 32'd1);
    chk("flip_q_kept", bus.Q, 32'h0000_0001);
    sendBits(w, DIR_RIGHT, 1, 30);
    chk("flip_no_early_valid", 32'(vCnt), 32'd0);
    sendBits(w, DIR_RIGHT, 31, 1);
    chk("flip_valid", 32'(bus.VALID), 32'd1);
    chk("flip_q", bus.Q, 32'hDEAD_BEEF);
    chk("flip_alert_count", 32'(aCnt), 32'd1);

    // Captures interleaved with disable / hold / rotate stalls
    w = 32'h0F0F_3C3C;
    vCnt = 0; aCnt = 0;
    for (int i = 0; i < 20; i++) begin
      sendBits(w, DIR_LEFT, i, 1);
      if (i < 15) begin
        case (i % 3)
          0:       drive(1'b0, MODO_SHIFT, DIR_RIGHT, i[0]);
          1:       drive(1'b1, MODO_HOLD,  DIR_RIGHT, ~i[0]);
          default: drive(1'b1, MODO_ROT,   DIR_RIGHT, i[0]);
        endcase
      end
    end
    chk("stall_cnt20", 32'(bus.CNT), 32'd20);
    chk("stall_no_alert", 32'(aCnt), 32'd0);
    chk("stall_no_valid", 32'(vCnt), 32'd0);
    sendBits(w, DIR_LEFT, 20, 11);
    chk("stall_no_early_valid", 32'(vCnt), 32'd0);
    sendBits(w, DIR_LEFT, 31, 1);
    chk("stall_valid", 32'(bus.VALID), 32'd1);
    chk("stall_q", bus.Q, 32'h0F0F_3C3C);

    // Asynchronous reset mid-frame, between clock edges
    w = 32'hFFFF_FFFF;
    sendBits(w, DIR_LEFT, 0, 17);
    chk("arst_cnt17", 32'(bus.CNT), 32'd17);
    #2;
    RST_L = 1'b0;
    #1;
    chk("arst_q", bus.Q, 32'h0);
    chk("arst_cnt", 32'(bus.CNT), 32'd0);
    chk("arst_valid", 32'(bus.VALID), 32'd0);
    chk("arst_alerta", 32'(bus.ALERTA), 32'd0);
`ifdef DESER_PARITY_EN
    chk("arst_par", 32'(bus.PAR), 32'd0);
`endif
    @(negedge CLK);
    RST_L = 1'b1;
    sendBits(w, DIR_LEFT, 0, 1);
    chk("arst_first_cnt", 32'(bus.CNT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
